uart_loader: RTL and testbench

Receive-side controller that sequences the byte stream from the UART receiver into program-memory writes. It parses a framed load command, streams assembled words into memory, and validates a trailing checksum. It holds the CPU in reset for the duration of the load. It sits between the UART receiver's byte strobe and the instruction-memory write port.

---
 rtl/uart_loader.sv | 151 +++++++++++++++
 tb/tb_uart_loader.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_loader.sv
// UART program loader: parses SYNC/ADDR/COUNT/DATA/CHK frames from the receiver
// byte strobe into instruction-memory writes, holding the CPU in reset meanwhile.
module uart_loader #(
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned WORD_W       = 22,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int unsigned TIMEOUT_CLKS = 100000
) (
  input  logic              clock,
  input  logic              i_reset_n,
  input  logic              i_data_avail,
  input  logic [7:0]        i_data_byte,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [WORD_W-1:0] o_mem_wdata,
  output logic              o_cpu_hold,
  output logic              o_done,
  output logic              o_error
);

  localparam int unsigned     TMO_W    = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CLKS - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ADDR_HI = 3'd1;
  localparam logic [2:0] S_ADDR_LO = 3'd2;
  localparam logic [2:0] S_COUNT   = 3'd3;
  localparam logic [2:0] S_DATA    = 3'd4;
  localparam logic [2:0] S_CHK     = 3'd5;

  logic [2:0]        state_q, state_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [8:0]        cnt_q, cnt_n;
  logic [1:0]        idx_q, idx_n;
  logic [15:0]       asm_q, asm_n;
  logic [7:0]        sum_q, sum_n;
  logic [TMO_W-1:0]  tmo_q, tmo_n;
  logic              we_n, done_n, err_n, hold_n;
  logic [ADDR_W-1:0] waddr_n;
  logic [WORD_W-1:0] wdata_n;
  logic [15:0]       addr_ext;
  logic [23:0]       word24;

  // Next-state and output decode; a byte strobe always beats timeout expiry
  always_comb begin
    state_n  = state_q;
    addr_n   = addr_q;
    cnt_n    = cnt_q;
    idx_n    = idx_q;
    asm_n    = asm_q;
    sum_n    = sum_q;
    tmo_n    = tmo_q;
    we_n     = 1'b0;
    waddr_n  = o_mem_addr;
    wdata_n  = o_mem_wdata;
    done_n   = 1'b0;
    err_n    = 1'b0;
    hold_n   = 1'b0;
    addr_ext = 16'(addr_q);
    word24   = {asm_q, i_data_byte};

    if (state_q == S_IDLE) begin
      tmo_n = '0;
      if (i_data_avail && (i_data_byte == SYNC_BYTE)) begin
        state_n = S_ADDR_HI;
        sum_n   = 8'h00;
        idx_n   = 2'd0;
      end
    end else if (i_data_avail) begin
      tmo_n = '0;
      sum_n = 8'(sum_q + i_data_byte);
      case (state_q)
        S_ADDR_HI: begin
          addr_n  = ADDR_W'({i_data_byte, 8'h00});
          state_n = S_ADDR_LO;
        end
        S_ADDR_LO: begin
          addr_n  = ADDR_W'({addr_ext[15:8], i_data_byte});
          state_n = S_COUNT;
        end
        S_COUNT: begin
          cnt_n   = (i_data_byte == 8'h00) ? 9'd256 : {1'b0, i_data_byte};
          idx_n   = 2'd0;
          state_n = S_DATA;
        end
        S_DATA: begin
          if (idx_q == 2'd2) begin
            we_n    = 1'b1;
            waddr_n = addr_q;
            wdata_n = WORD_W'(word24);
            addr_n  = addr_q + 1'b1;
            cnt_n   = cnt_q - 9'd1;
            idx_n   = 2'd0;
            if (cnt_q == 9'd1) state_n = S_CHK;
          end else begin
            asm_n = {asm_q[7:0], i_data_byte};
            idx_n = idx_q + 2'd1;
          end
        end
        S_CHK: begin
          if (8'(sum_q + i_data_byte) == 8'h00) done_n = 1'b1;
          else                                  err_n  = 1'b1;
          state_n = S_IDLE;
        end
        default: state_n = S_IDLE;
      endcase
    end else if (tmo_q == TMO_LAST) begin
      err_n   = 1'b1;
      tmo_n   = '0;
      state_n = S_IDLE;
    end else begin
      tmo_n = tmo_q + 1'b1;
    end

    hold_n = (state_n != S_IDLE);
  end

  // State, datapath and registered outputs
  always_ff @(posedge clock) begin
    if (!i_reset_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      asm_q       <= '0;
      sum_q       <= '0;
      tmo_q       <= '0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_cpu_hold  <= 1'b0;
      o_done      <= 1'b0;
      o_error     <= 1'b0;
    end else begin
      state_q     <= state_n;
      addr_q      <= addr_n;
      cnt_q       <= cnt_n;
      idx_q       <= idx_n;
      asm_q       <= asm_n;
      sum_q       <= sum_n;
      tmo_q       <= tmo_n;
      o_mem_we    <= we_n;
      o_mem_addr  <= waddr_n;
      o_mem_wdata <= wdata_n;
      o_cpu_hold  <= hold_n;
      o_done      <= done_n;
      o_error     <= err_n;
    end
  end

endmodule

// File: tb/tb_uart_loader.sv
// Bench for uart_loader: frame-level reference model checked every cycle, plus
// literal expectations on captured writes and pulse counts per directed test.
module tb_uart_loader;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned WORD_W = 22;
  localparam int unsigned TMO    = 64;

  logic              clock = 1'b0;
  logic              i_reset_n = 1'b0;
  logic              i_data_avail = 1'b0;
  logic [7:0]        i_data_byte = 8'h00;
  logic              o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [WORD_W-1:0] o_mem_wdata;
  logic              o_cpu_hold;
  logic              o_done;
  logic              o_error;

  uart_loader #(
    .ADDR_W(ADDR_W), .WORD_W(WORD_W), .SYNC_BYTE(8'hA5), .TIMEOUT_CLKS(TMO)
  ) dut (
    .clock(clock), .i_reset_n(i_reset_n), .i_data_avail(i_data_avail),
    .i_data_byte(i_data_byte), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_cpu_hold(o_cpu_hold), .o_done(o_done),
    .o_error(o_error)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: interprets the frame by byte position after SYNC
  logic              e_we = 1'b0, e_done = 1'b0, e_err = 1'b0, e_hold = 1'b0;
  logic [ADDR_W-1:0] e_addr = '0;
  logic [WORD_W-1:0] e_wdata = '0;
  bit                m_in = 1'b0;
  logic [7:0]        m_fb[$];
  int                m_words = 0;
  int                m_idle = 0;

  task automatic model_step(input logic av, input logic [7:0] b, input logic rn);
    int n, s, base;
    e_we = 1'b0; e_done = 1'b0; e_err = 1'b0;
    if (!rn) begin
      m_in = 1'b0; e_addr = '0; e_wdata = '0;
    end else if (!m_in) begin
      if (av && b == 8'hA5) begin
        m_in = 1'b1; m_fb.delete(); m_idle = 0;
      end
    end else if (av) begin
      m_fb.push_back(b);
      m_idle = 0;
      n = m_fb.size() - 1;
      if (n == 2) m_words = (b == 8'h00) ? 256 : int'(b);
      if (n >= 3 && n < 3 + 3 * m_words && (n - 3) % 3 == 2) begin
        base    = int'({m_fb[0], m_fb[1]});
        e_we    = 1'b1;
        e_addr  = ADDR_W'(base + (n - 3) / 3);
        e_wdata = WORD_W'({m_fb[n-2], m_fb[n-1], m_fb[n]});
      end else if (n >= 3 && n == 3 + 3 * m_words) begin
        s = 0;
        foreach (m_fb[i]) s += int'(m_fb[i]);
        if (s % 256 == 0) e_done = 1'b1;
        else              e_err  = 1'b1;
        m_in = 1'b0;
      end
    end else begin
      m_idle++;
      if (m_idle == TMO) begin
        e_err = 1'b1; m_in = 1'b0;
      end
    end
    e_hold = m_in;
  endtask

  // Captured DUT activity for the literal checks
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          done_cnt = 0;
  int          err_cnt = 0;

  always @(negedge clock) begin
    chk("we",    32'(o_mem_we),    32'(e_we));
    chk("addr",  32'(o_mem_addr),  32'(e_addr));
    chk("wdata", 32'(o_mem_wdata), 32'(e_wdata));
    chk("hold",  32'(o_cpu_hold),  32'(e_hold));
    chk("done",  32'(o_done),      32'(e_done));
    chk("error", 32'(o_error),     32'(e_err));
    if (o_mem_we === 1'b1) begin
      wr_addr.push_back(32'(o_mem_addr));
      wr_data.push_back(32'(o_mem_wdata));
    end
    if (o_done === 1'b1)  done_cnt++;
    if (o_error === 1'b1) err_cnt++;
  end

  task automatic tick(input logic av, input logic [7:0] b, input logic rn);
    i_data_avail = av;
    i_data_byte  = b;
    i_reset_n    = rn;
    @(posedge clock);
    model_step(av, b, rn);
    #1;
    i_data_avail = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 8'h00, 1'b1);
  endtask

  task automatic send_frame(input logic [7:0] fr[$]);
    foreach (fr[i]) tick(1'b1, fr[i], 1'b1);
  endtask

  task automatic clear_log();
    wr_addr.delete(); wr_data.delete(); done_cnt = 0; err_cnt = 0;
  endtask

  logic [7:0] fr[$];
  int         s;

  initial begin
    tick(1'b0, 8'h00, 1'b0);
    tick(1'b0, 8'h00, 1'b0);
    idle(2);
    chk("reset_hold", 32'(o_cpu_hold), 32'd0);

    clear_log();
    fr = '{8'hA5, 8'h00, 8'h10, 8'h01, 8'h01, 8'h23, 8'h45, 8'h86};
    send_frame(fr); idle(3);
    chk("t1_nwr", 32'(wr_addr.size()), 32'd1);
    chk("t1_addr", wr_addr[0], 32'h010);
    chk("t1_data", wr_data[0], 32'h012345);
    chk("t1_done", 32'(done_cnt), 32'd1);
    chk("t1_err", 32'(err_cnt), 32'd0);

    clear_log();
    fr = '{8'hA5, 8'h00, 8'h10, 8'h01, 8'h01, 8'h23, 8'h45, 8'h87};
    send_frame(fr); idle(3);
    chk("t2_addr", wr_addr[0], 32'h010);
    chk("t2_done", 32'(done_cnt), 32'd0);
    chk("t2_err", 32'(err_cnt), 32'd1);

    clear_log();
    fr = '{8'hA5, 8'h03, 8'hFF, 8'h02, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h01, 8'hFE};
    send_frame(fr); idle(3);
    chk("t3_nwr", 32'(wr_addr.size()), 32'd2);
    chk("t3_a0", wr_addr[0], 32'h3FF);
    chk("t3_d0", wr_data[0], 32'h3FFFFF);
    chk("t3_a1", wr_addr[1], 32'h000);
    chk("t3_d1", wr_data[1], 32'h000001);
    chk("t3_done", 32'(done_cnt), 32'd1);

    clear_log();
    fr = '{8'hA5, 8'h00, 8'h00, 8'h01, 8'h12, 8'h34};
    send_frame(fr); idle(TMO + 5);
    chk("t4_nwr", 32'(wr_addr.size()), 32'd0);
    chk("t4_err", 32'(err_cnt), 32'd1);
    chk("t4_hold", 32'(o_cpu_hold), 32'd0);

    // Byte lands on the expiry cycle; SYNC value inside data is plain data
    clear_log();
    fr = '{8'hA5, 8'h00, 8'h20, 8'h01};
    send_frame(fr); idle(TMO - 1);
    fr = '{8'hA5, 8'h0B, 8'h0C, 8'h23};
    send_frame(fr); idle(3);
    chk("t5_nwr", 32'(wr_addr.size()), 32'd1);
    chk("t5_addr", wr_addr[0], 32'h020);
    chk("t5_data", wr_data[0], 32'h250B0C);
    chk("t5_done", 32'(done_cnt), 32'd1);
    chk("t5_err", 32'(err_cnt), 32'd0);

    clear_log();
    fr = '{8'h00, 8'hFF, 8'h5A};
    send_frame(fr); idle(2);
    chk("t6_idle_hold", 32'(o_cpu_hold), 32'd0);
    fr = '{8'hA5, 8'h00, 8'h00, 8'h01};
    send_frame(fr);
    tick(1'b0, 8'h00, 1'b0);
    idle(TMO + 5);
    chk("t6_nwr", 32'(wr_addr.size()), 32'd0);
    chk("t6_pulses", 32'(done_cnt + err_cnt), 32'd0);
    chk("t6_hold", 32'(o_cpu_hold), 32'd0);
    fr = '{8'hA5, 8'h00, 8'h10, 8'h01, 8'h01, 8'h23, 8'h45, 8'h86};
    send_frame(fr); idle(3);
    chk("t6_done", 32'(done_cnt), 32'd1);
    chk("t6_nwr2", 32'(wr_addr.size()), 32'd1);

    clear_log();
    fr = '{8'hA5, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 256; i++) begin
      fr.push_back(8'(i)); fr.push_back(8'(~i)); fr.push_back(8'h5A);
    end
    s = 0;
    for (int i = 1; i < fr.size(); i++) s += int'(fr[i]);
    fr.push_back(8'(256 - (s % 256)));
    send_frame(fr); idle(3);
    chk("t7_nwr", 32'(wr_addr.size()), 32'd256);
    chk("t7_a0", wr_addr[0], 32'h000);
    chk("t7_d0", wr_data[0], 32'h00FF5A);
    chk("t7_a255", wr_addr[255], 32'h0FF);
    chk("t7_d255", wr_data[255], 32'h3F005A);
    chk("t7_done", 32'(done_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
